neuron_feeder: RTL and testbench

//  Layer sequencer directly upstream of neuron_top. Holds one layer's FP16 weights (1-5-10 format),

---
 rtl/nf_pkg.sv | 23 ++
 rtl/nf_weight_ram.sv | 31 +++
 rtl/neuron_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_neuron_feeder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_pkg.sv
// Shared types and constants for the neuron_feeder layer sequencer.
package nf_pkg;

  typedef logic [15:0] fp16_t;

  localparam int    FP_EXP_W  = 5;
  localparam int    FP_MAN_W  = 10;
  localparam fp16_t FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // True for +0 and -0: exponent and mantissa both clear, sign ignored.
  function automatic logic fp16_is_zero(input fp16_t v);
    return v[FP_EXP_W+FP_MAN_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/nf_weight_ram.sv
// Weight store: one write port, one synchronous read port (address in cycle t, data in t+1).
module nf_weight_ram
  import nf_pkg::*;
#(
  parameter int DEPTH = 25,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fp16_t         wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output fp16_t         rd_data_o
);

  fp16_t mem_q [DEPTH];
  fp16_t rd_data_q;

  // Contents are deliberately not reset; the layer is always reloaded by software.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (int'(rd_addr_i) < DEPTH) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/neuron_feeder.sv
// Layer sequencer in front of neuron_top: latches inputs, fetches 3 weights per neuron,
// hands them over and collects each result. Optional zero-weight skipping via SKIP_ZERO_EN.
//
// Handshake: done1..3 is a level that stays high from the first RUN cycle until the cycle
// neuron_done is sampled high; res_valid and layer_done are single-cycle pulses with no
// back-pressure; start/wr_en are accepted only while busy is low.
module neuron_feeder
  import nf_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int MEM_DEPTH   = 25,
  parameter int AW          = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [15:0]   xin1,
  input  logic [15:0]   xin2,
  input  logic [15:0]   xin3,
  output logic [15:0]   x1,
  output logic [15:0]   x2,
  output logic [15:0]   x3,
  output logic [15:0]   w1,
  output logic [15:0]   w2,
  output logic [15:0]   w3,
  output logic          done1,
  output logic          done2,
  output logic          done3,
  input  logic          neuron_done,
  input  logic [15:0]   f,
  output logic          res_valid,
  output logic [AW-1:0] res_idx,
  output logic [15:0]   res_data,
  output logic          busy,
  output logic          layer_done,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    k_q, k_d;
  fp16_t         x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  fp16_t         w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  fp16_t         res_data_q, res_data_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic          done_q, done_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;
  logic          layer_done_q, layer_done_d;

  fp16_t         rd_data;
  logic          ram_we;

  // Writes are frozen while a layer runs so the weights cannot change under a neuron.
  assign ram_we = wr_en && !busy_q && (int'(wr_addr) < MEM_DEPTH);

  nf_weight_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk),
    .we_i      (ram_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    addr_d       = addr_q;
    k_d          = k_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    x3_d         = x3_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    res_data_d   = res_data_q;
    res_idx_d    = res_idx_q;
    done_d       = done_q;
    res_valid_d  = 1'b0;
    busy_d       = busy_q;
    layer_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x1_d    = xin1;
          x2_d    = xin2;
          x3_d    = xin3;
          n_d     = '0;
          k_d     = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // addr_q walks 3n..3n+3; read data lags the address by one cycle.
        unique case (k_q)
          2'd1:    w1_d = rd_data;
          2'd2:    w2_d = rd_data;
          2'd3:    w3_d = rd_data;
          default: ;
        endcase
        k_d = k_q + 2'd1;
        if (k_q != 2'd3) begin
          addr_d = addr_q + AW'(1);
        end else begin
`ifdef SKIP_ZERO_EN
          if (fp16_is_zero(w1_q) && fp16_is_zero(w2_q) && fp16_is_zero(rd_data)) begin
            res_data_d  = FP16_ZERO;
            res_idx_d   = n_q;
            res_valid_d = 1'b1;
            state_d     = GAP;
          end else begin
            done_d  = 1'b1;
            state_d = RUN;
          end
`else
          done_d  = 1'b1;
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (neuron_done) begin
          res_data_d  = f;
          res_idx_d   = n_q;
          res_valid_d = 1'b1;
          done_d      = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        // done is low here, so a neuron_done still held high is not taken twice.
        if (n_q == AW'(NUM_NEURONS - 1)) begin
          layer_done_d = 1'b1;
          state_d      = DONE;
        end else begin
          n_d     = n_q + AW'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      addr_q       <= '0;
      k_q          <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      k_q          <= k_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
      done_q       <= done_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign x1         = x1_q;
  assign x2         = x2_q;
  assign x3         = x3_q;
  assign w1         = w1_q;
  assign w2         = w2_q;
  assign w3         = w3_q;
  assign done1      = done_q;
  assign done2      = done_q;
  assign done3      = done_q;
  assign res_valid  = res_valid_q;
  assign res_idx    = res_idx_q;
  assign res_data   = res_data_q;
  assign busy       = busy_q;
  assign layer_done = layer_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Self-checking bench for neuron_feeder with a behavioural neuron_top responder and layer model.
module tb_neuron_feeder;
  localparam int NN = 8;
  localparam int MD = 25;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          start = 1'b0;
  logic [15:0]   xin1 = '0, xin2 = '0, xin3 = '0;
  logic [15:0]   x1, x2, x3, w1, w2, w3;
  logic          done1, done2, done3;
  logic          neuron_done = 1'b0;
  logic [15:0]   f = '0;
  logic          res_valid;
  logic [AW-1:0] res_idx;
  logic [15:0]   res_data;
  logic          busy, layer_done;
  nf_pkg::state_e dbg_state;

  neuron_feeder #(.NUM_NEURONS(NN), .MEM_DEPTH(MD), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .xin1(xin1), .xin2(xin2), .xin3(xin3),
    .x1(x1), .x2(x2), .x3(x3), .w1(w1), .w2(w2), .w3(w3),
    .done1(done1), .done2(done2), .done3(done3),
    .neuron_done(neuron_done), .f(f),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .layer_done(layer_done), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [15:0]    mm [MD];
  logic [AW+15:0] exp_q[$];
  int             exp_rises;

  function automatic logic [15:0] model_f(input logic [15:0] a, b, c, xa, xb, xc);
    return a ^ {b[10:0], b[15:11]} ^ (c + xa) ^ xb ^ {xc[7:0], xc[15:8]};
  endfunction

  function automatic bit is_signed_zero(input logic [15:0] v);
    return v[14:0] == 15'd0;
  endfunction

  task automatic build_exp(input logic [15:0] xa, xb, xc);
    logic [15:0] a, b, c;
    bit skip;
    exp_q.delete();
    exp_rises = 0;
    for (int n = 0; n < NN; n++) begin
      a = mm[3*n]; b = mm[3*n+1]; c = mm[3*n+2];
      skip = 1'b0;
`ifdef SKIP_ZERO_EN
      skip = is_signed_zero(a) && is_signed_zero(b) && is_signed_zero(c);
`endif
      if (skip) exp_q.push_back({AW'(n), 16'h0000});
      else begin
        exp_q.push_back({AW'(n), model_f(a, b, c, xa, xb, xc)});
        exp_rises++;
      end
    end
  endtask

  // ---------------- behavioural neuron_top ----------------
  int resp_en = 0, resp_lat = 3, resp_hold = 0;
  int resp_cnt = 0, hold_left = 0;
  always @(posedge clk) begin
    #1;
    if (resp_en == 0) begin
      neuron_done = 1'b0; resp_cnt = 0; hold_left = 0;
    end else if (done1) begin
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        neuron_done = 1'b1;
        f = model_f(w1, w2, w3, x1, x2, x3);
      end
      hold_left = resp_hold;
    end else begin
      resp_cnt = 0;
      if (hold_left > 0) hold_left--;
      else neuron_done = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic [AW+15:0] obs_q[$];
  int obs_cyc_q[$], rise_cyc_q[$], nd_cyc_q[$], ld_cyc_q[$];
  logic ld_busy_q[$], post_ld_busy_q[$];
  int uneq_cnt = 0;
  logic done1_prev = 1'b0, ld_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      done1_prev = 1'b0; ld_prev = 1'b0;
    end else begin
      if (res_valid) begin obs_q.push_back({res_idx, res_data}); obs_cyc_q.push_back(cyc); end
      if (layer_done) begin ld_cyc_q.push_back(cyc); ld_busy_q.push_back(busy); end
      if (ld_prev) post_ld_busy_q.push_back(busy);
      if (done1 && !done1_prev) rise_cyc_q.push_back(cyc);
      if (done1 && neuron_done) nd_cyc_q.push_back(cyc);
      if (done1 !== done2 || done1 !== done3) uneq_cnt++;
      done1_prev = done1; ld_prev = layer_done;
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc;

  task automatic clear_obs();
    obs_q.delete(); obs_cyc_q.delete(); rise_cyc_q.delete(); nd_cyc_q.delete();
    ld_cyc_q.delete(); ld_busy_q.delete(); post_ld_busy_q.delete();
  endtask

  task automatic write_w(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (int'(a) < MD) mm[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_random();
    for (int a = 0; a < 3*NN; a++) write_w(AW'(a), 16'($urandom) | 16'h0001);
  endtask

  task automatic start_layer(input logic [15:0] xa, xb, xc, input bit do_wr,
                             input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    xin1 = xa; xin2 = xb; xin3 = xc; start = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      mm[a] = d;
    end
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_layer(input string name);
    int b = 0;
    while (ld_cyc_q.size() == 0 && b < 3000) begin @(negedge clk); b++; end
    if (ld_cyc_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no layer_done expected layer_done within 3000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [134:0] outs;
    repeat (3) @(negedge clk);
    outs = {x1, x2, x3, w1, w2, w3, done1, done2, done3, res_valid, res_idx, res_data, busy, layer_done};
    n_cmp++;
    if (outs !== '0 || dbg_state !== nf_pkg::IDLE) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected all zero", outs);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_neuron();
    logic [15:0] xa, xb, xc;
    int b = 0;
    xa = 16'h081C; xb = 16'h0CA1; xc = 16'h1C1F;
    load_random();
    write_w(5'd0, 16'h041A); write_w(5'd1, 16'h238D); write_w(5'd2, 16'h21DF);
    resp_en = 0; resp_hold = 0;
    clear_obs();
    start_layer(xa, xb, xc, 1'b0, '0, '0);
    build_exp(xa, xb, xc);
    while (rise_cyc_q.size() == 0 && b < 50) begin @(negedge clk); b++; end
    n_cmp++;
    if (rise_cyc_q.size() == 0 || rise_cyc_q[0] - start_cyc != 5) begin
      n_fail++;
      $display("FAIL first_latency: got %0d expected 5 cycles", rise_cyc_q.size() ? rise_cyc_q[0] - start_cyc : -1);
    end
    n_cmp++;
    if ({x1, x2, x3} !== {xa, xb, xc}) begin
      n_fail++; $display("FAIL first_x: got %h %h %h expected %h %h %h", x1, x2, x3, xa, xb, xc);
    end
    n_cmp++;
    if ({w1, w2, w3} !== {16'h041A, 16'h238D, 16'h21DF}) begin
      n_fail++; $display("FAIL first_w: got %h %h %h expected 041a 238d 21df", w1, w2, w3);
    end
    n_cmp++;
    if ({done1, done2, done3} !== 3'b111) begin
      n_fail++; $display("FAIL first_done: got %b expected 111", {done1, done2, done3});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || obs_q.size() != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_wait: got done1=%b results=%0d busy=%b expected 1 0 1", done1, obs_q.size(), busy);
    end
    resp_lat = 2; resp_en = 1;
    wait_layer("first");
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL first_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL first_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_layer();
    logic [15:0] xa, xb, xc;
    int bad_lat = 0;
    load_random();
    xa = 16'($urandom); xb = 16'($urandom); xc = 16'($urandom);
    resp_en = 1; resp_lat = 3; resp_hold = 0;
    clear_obs();
    start_layer(xa, xb, xc, 1'b0, '0, '0);
    build_exp(xa, xb, xc);
    wait_layer("full");
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (ld_cyc_q.size() != 1 || obs_cyc_q.size() == 0 || ld_cyc_q[0] != obs_cyc_q[$] + 1) begin
      n_fail++; $display("FAIL full_layer_done_timing: got %0d pulses expected 1 pulse one cycle after last result", ld_cyc_q.size());
    end
    n_cmp++;
    if (ld_busy_q.size() != 1 || ld_busy_q[0] !== 1'b1 || post_ld_busy_q.size() == 0 || post_ld_busy_q[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_busy_fall: got busy not falling with layer_done expected busy 1 then 0");
    end
    for (int i = 0; i < nd_cyc_q.size() && i < obs_cyc_q.size(); i++) begin
      if (obs_cyc_q[i] - nd_cyc_q[i] != 1) bad_lat++;
      if (i + 1 < rise_cyc_q.size() && rise_cyc_q[i+1] - nd_cyc_q[i] != 6) bad_lat++;
    end
    n_cmp++;
    if (bad_lat != 0 || nd_cyc_q.size() != NN) begin
      n_fail++; $display("FAIL full_latency: got %0d bad latencies (%0d handshakes) expected 0 (%0d)", bad_lat, nd_cyc_q.size(), NN);
    end
    n_cmp++;
    if (uneq_cnt != 0) begin
      n_fail++; $display("FAIL done_equal: got %0d unequal cycles expected 0", uneq_cnt);
    end
  endtask

  task automatic test_hold_done();
    logic [15:0] xa, xb, xc, nw;
    xa = 16'($urandom); xb = 16'($urandom); xc = 16'($urandom);
    nw = 16'($urandom) | 16'h0100;
    resp_en = 1; resp_lat = $urandom_range(1, 4); resp_hold = 3;
    clear_obs();
    // Weight write and start land in the same idle cycle; the new weight must be used.
    start_layer(xa, xb, xc, 1'b1, 5'd0, nw);
    build_exp(xa, xb, xc);
    wait_layer("hold");
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL hold_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL hold_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    resp_hold = 0;
  endtask

  task automatic test_busy_ignore();
    logic [15:0] xa, xb, xc;
    int b = 0;
    xa = 16'($urandom); xb = 16'($urandom); xc = 16'($urandom);
    resp_en = 1; resp_lat = 4; resp_hold = 0;
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      start_layer(xa, xb, xc, 1'b0, '0, '0);
      build_exp(xa, xb, xc);
      b = 0;
      while (ld_cyc_q.size() == 0 && b < 3000) begin
        @(negedge clk);
        b++;
        if (pass == 0 && (b == 20 || b == 60)) begin
          start = 1'b1; xin1 = ~xa; xin2 = ~xb; xin3 = ~xc;
          wr_en = 1'b1; wr_addr = (b == 20) ? 5'd0 : 5'd5; wr_data = ~mm[wr_addr];
        end else begin
          start = 1'b0; wr_en = 1'b0;
        end
      end
      start = 1'b0; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != exp_q.size() || rise_cyc_q.size() != exp_rises) begin
        n_fail++; $display("FAIL busy_ignore_count[%0d]: got %0d results %0d issues expected %0d %0d",
                           pass, obs_q.size(), rise_cyc_q.size(), exp_q.size(), exp_rises);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL busy_ignore_result[%0d][%0d]: got %h expected %h", pass, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [134:0] outs;
    logic [15:0] xa, xb, xc;
    int b = 0;
    xa = 16'($urandom); xb = 16'($urandom); xc = 16'($urandom);
    resp_en = 1; resp_lat = 10; resp_hold = 0;
    clear_obs();
    start_layer(xa, xb, xc, 1'b0, '0, '0);
    while (!(obs_q.size() == 3 && done1 === 1'b1) && b < 2000) begin @(negedge clk); b++; end
    n_cmp++;
    if (!(obs_q.size() == 3 && done1 === 1'b1)) begin
      n_fail++; $display("FAIL reset_mid_reach: got %0d results done1=%b expected 3 and 1", obs_q.size(), done1);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    outs = {x1, x2, x3, w1, w2, w3, done1, done2, done3, res_valid, res_idx, res_data, busy, layer_done};
    n_cmp++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected all zero", outs);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ld_cyc_q.size() != 0 || obs_q.size() != 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_abort: got layer_done=%0d results=%0d busy=%b expected 0 3 0",
                         ld_cyc_q.size(), obs_q.size(), busy);
    end
    load_random();
    resp_lat = 2;
    clear_obs();
    start_layer(xa, xb, xc, 1'b0, '0, '0);
    build_exp(xa, xb, xc);
    wait_layer("reset_mid_rerun");
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL reset_mid_rerun_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_mid_rerun[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_skip_zero();
    logic [15:0] xa, xb, xc;
    xa = 16'($urandom); xb = 16'($urandom); xc = 16'($urandom);
    load_random();
    write_w(5'd3, 16'h8000); write_w(5'd4, 16'h0000); write_w(5'd5, 16'h0000);
    resp_en = 1; resp_lat = 2; resp_hold = 0;
    clear_obs();
    start_layer(xa, xb, xc, 1'b0, '0, '0);
    build_exp(xa, xb, xc);
    wait_layer("skip");
    n_cmp++;
    if (rise_cyc_q.size() != exp_rises) begin
      n_fail++; $display("FAIL skip_issues: got %0d expected %0d", rise_cyc_q.size(), exp_rises);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL skip_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL skip_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_neuron();
    test_full_layer();
    test_hold_done();
    test_busy_ignore();
    test_reset_mid();
    test_skip_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
